rvm_ddr3_bridge: RTL and testbench

//  Converts the rvm_core memory port (addr/rdata/wdata/c_en/w_en/b_en/error/stall) into MIG DDR3 app-interface cmds.

---
 rtl/rvm_ddr3_bridge_if.sv | 42 ++++
 rtl/rvm_ddr3_bridge.sv | 130 +++++++++++++
 tb/tb_rvm_ddr3_bridge.sv | 441 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rvm_ddr3_bridge_if.sv
// Core memory port and MIG app-interface bundle for rvm_ddr3_bridge.
// slave = bridge view; master = core + MIG side.
interface rvm_ddr3_bridge_if;
    logic [31:0]  mem_addr;
    logic [31:0]  mem_rdata;
    logic [31:0]  mem_wdata;
    logic         mem_c_en;
    logic         mem_w_en;
    logic [3:0]   mem_b_en;
    logic         mem_error;
    logic         mem_stall;
    logic         init_calib_complete;
    logic [27:0]  app_addr;
    logic [2:0]   app_cmd;
    logic         app_en;
    logic         app_rdy;
    logic [127:0] app_wdf_data;
    logic [15:0]  app_wdf_mask;
    logic         app_wdf_wren;
    logic         app_wdf_end;
    logic         app_wdf_rdy;
    logic [127:0] app_rd_data;
    logic         app_rd_data_valid;

    modport slave (
        input  mem_addr, mem_wdata, mem_c_en, mem_w_en, mem_b_en,
        input  init_calib_complete, app_rdy, app_wdf_rdy,
        input  app_rd_data, app_rd_data_valid,
        output mem_rdata, mem_error, mem_stall,
        output app_addr, app_cmd, app_en,
        output app_wdf_data, app_wdf_mask, app_wdf_wren, app_wdf_end
    );

    modport master (
        output mem_addr, mem_wdata, mem_c_en, mem_w_en, mem_b_en,
        output init_calib_complete, app_rdy, app_wdf_rdy,
        output app_rd_data, app_rd_data_valid,
        input  mem_rdata, mem_error, mem_stall,
        input  app_addr, app_cmd, app_en,
        input  app_wdf_data, app_wdf_mask, app_wdf_wren, app_wdf_end
    );
endinterface

// File: rtl/rvm_ddr3_bridge.sv
// rvm_core word port to MIG DDR3 app interface, one BL8 access per word.
// Single outstanding access; writes are posted once cmd and data are taken.
module rvm_ddr3_bridge #(
    parameter logic [31:0] MEM_BYTES  = 32'h1000_0000,
    parameter int          RD_TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             reset,
    rvm_ddr3_bridge_if.slave bus
);
    localparam int CW = $clog2(RD_TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(RD_TIMEOUT);

    typedef enum logic [2:0] {
        IDLE, WR, RD_CMD, RD_WAIT, RESP, ERR
    } state_t;

    state_t        state_q, state_d;
    logic [23:0]   line_q, line_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [15:0]   mask_q, mask_d;
    logic [1:0]    sel_q, sel_d;
    logic          cmd_done_q, cmd_done_d;
    logic          dat_done_q, dat_done_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          app_en;
    logic          wren;

    // State, latched request and read-response registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            line_q     <= '0;
            wdata_q    <= '0;
            mask_q     <= '1;
            sel_q      <= '0;
            cmd_done_q <= 1'b0;
            dat_done_q <= 1'b0;
            cnt_q      <= '0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            line_q     <= line_d;
            wdata_q    <= wdata_d;
            mask_q     <= mask_d;
            sel_q      <= sel_d;
            cmd_done_q <= cmd_done_d;
            dat_done_q <= dat_done_d;
            cnt_q      <= cnt_d;
            rdata_q    <= rdata_d;
        end
    end

    // Next state plus app_en / app_wdf_wren strobes
    always_comb begin
        state_d    = state_q;
        line_d     = line_q;
        wdata_d    = wdata_q;
        mask_d     = mask_q;
        sel_d      = sel_q;
        cmd_done_d = cmd_done_q;
        dat_done_d = dat_done_q;
        cnt_d      = cnt_q;
        rdata_d    = rdata_q;
        app_en     = 1'b0;
        wren       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.mem_c_en && bus.init_calib_complete) begin
                    line_d     = bus.mem_addr[27:4];
                    wdata_d    = bus.mem_wdata;
                    mask_d     = ~({12'b0, bus.mem_b_en}
                                   << {bus.mem_addr[3:2], 2'b00});
                    sel_d      = bus.mem_addr[3:2];
                    cmd_done_d = 1'b0;
                    dat_done_d = 1'b0;
                    if (bus.mem_addr >= MEM_BYTES) begin
                        rdata_d = '0;
                        state_d = ERR;
                    end else if (bus.mem_w_en) begin
                        state_d = WR;
                    end else begin
                        state_d = RD_CMD;
                    end
                end
            end
            WR: begin
                app_en     = !cmd_done_q;
                wren       = !dat_done_q;
                cmd_done_d = cmd_done_q | (app_en & bus.app_rdy);
                dat_done_d = dat_done_q | (wren & bus.app_wdf_rdy);
                if (cmd_done_d && dat_done_d) state_d = RESP;
            end
            RD_CMD: begin
                app_en = 1'b1;
                if (bus.app_rdy) begin
                    cnt_d   = '0;
                    state_d = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (bus.app_rd_data_valid) begin
                    rdata_d = bus.app_rd_data[32*sel_q +: 32];
                    state_d = RESP;
                end else if (cnt_q == CNT_MAX) begin
                    rdata_d = '0;
                    state_d = ERR;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign bus.mem_stall    = bus.mem_c_en
                            & ~(state_q == RESP | state_q == ERR);
    assign bus.mem_error    = (state_q == ERR);
    assign bus.mem_rdata    = rdata_q;
    assign bus.app_addr     = {1'b0, line_q, 3'b000};
    assign bus.app_cmd      = (state_q == WR) ? 3'b000 : 3'b001;
    assign bus.app_en       = app_en;
    assign bus.app_wdf_data = {4{wdata_q}};
    assign bus.app_wdf_mask = mask_q;
    assign bus.app_wdf_wren = wren;
    assign bus.app_wdf_end  = wren;
endmodule

// File: tb/tb_rvm_ddr3_bridge.sv
// Bench for rvm_ddr3_bridge: core-side driver, small 1 KB MIG model
// with programmable latency/backpressure, and an expected-result queue.
module tb_rvm_ddr3_bridge;
    localparam int          TMO  = 255;
    localparam logic [31:0] MEMB = 32'h1000_0000;

    typedef struct {
        logic [31:0] rd;
        logic        er;
        logic        chk;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    rvm_ddr3_bridge_if bus();

    rvm_ddr3_bridge #(
        .MEM_BYTES (MEMB),
        .RD_TIMEOUT(TMO)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    exp_t sbq[$];
    bit [31:0]  wm [256];
    bit [127:0] mig_mem [64];

    int mig_lat = 0;
    bit mig_on  = 1'b1;
    int en_cnt = 0, wr_cnt = 0, en_stall = 0, wr_stall = 0;
    int en_base = 0, wr_base = 0, en_wait = 0, wr_wait = 0;
    int acc_en, acc_wr;
    bit rd_pend = 1'b0;
    int rd_cnt = 0;
    bit [127:0] rd_line;
    logic [27:0]  cap_addr;
    logic [2:0]   cap_cmd;
    logic [15:0]  cap_mask;
    logic [127:0] cap_data;

    assign bus.app_rdy     = (en_stall - en_base) >= en_wait;
    assign bus.app_wdf_rdy = (wr_stall - wr_base) >= wr_wait;

    function automatic bit [127:0] merge(input bit [127:0] old,
                                         input logic [127:0] dat,
                                         input logic [15:0] m);
        for (int b = 0; b < 16; b++)
            if (!m[b]) old[8*b +: 8] = dat[8*b +: 8];
        return old;
    endfunction

    // MIG model: counts strobes, captures commands, returns read lines
    always @(posedge clk) begin
        bus.app_rd_data_valid <= 1'b0;
        if (bus.app_en) en_cnt <= en_cnt + 1;
        if (bus.app_en && !bus.app_rdy) en_stall <= en_stall + 1;
        if (bus.app_wdf_wren) wr_cnt <= wr_cnt + 1;
        if (bus.app_wdf_wren && !bus.app_wdf_rdy) wr_stall <= wr_stall + 1;
        if (rd_pend) begin
            if (rd_cnt <= 1) begin
                bus.app_rd_data_valid <= 1'b1;
                bus.app_rd_data       <= rd_line;
                rd_pend               <= 1'b0;
            end else begin
                rd_cnt <= rd_cnt - 1;
            end
        end
        if (bus.app_en && bus.app_rdy) begin
            cap_addr <= bus.app_addr;
            cap_cmd  <= bus.app_cmd;
            if (bus.app_cmd == 3'b001 && mig_on) begin
                if (mig_lat == 0) begin
                    bus.app_rd_data_valid <= 1'b1;
                    bus.app_rd_data <= mig_mem[bus.app_addr[8:3]];
                end else begin
                    rd_pend <= 1'b1;
                    rd_cnt  <= mig_lat;
                    rd_line <= mig_mem[bus.app_addr[8:3]];
                end
            end
        end
        if (bus.app_wdf_wren && bus.app_wdf_rdy) begin
            cap_mask <= bus.app_wdf_mask;
            cap_data <= bus.app_wdf_data;
            mig_mem[bus.app_addr[8:3]] <= merge(mig_mem[bus.app_addr[8:3]],
                                                bus.app_wdf_data,
                                                bus.app_wdf_mask);
        end
    end

    function automatic exp_t model(input logic [31:0] a, input logic w,
                                   input logic [31:0] d,
                                   input logic [3:0] be);
        exp_t e;
        e.er  = !(a < MEMB);
        e.chk = !w && !e.er;
        e.rd  = wm[a[9:2]];
        if (w && !e.er)
            for (int j = 0; j < 4; j++)
                if (be[j]) wm[a[9:2]][8*j +: 8] = d[8*j +: 8];
        return e;
    endfunction

    task automatic access(input logic [31:0] a, input logic w,
                          input logic [31:0] d, input logic [3:0] be,
                          output logic [31:0] rd, output logic er,
                          output int cyc);
        int e0, w0;
        @(negedge clk);
        en_base = en_stall;
        wr_base = wr_stall;
        e0 = en_cnt;
        w0 = wr_cnt;
        bus.mem_addr  = a;
        bus.mem_w_en  = w;
        bus.mem_wdata = d;
        bus.mem_b_en  = be;
        bus.mem_c_en  = 1'b1;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (bus.mem_stall === 1'b1 && cyc < 400);
        rd = bus.mem_rdata;
        er = bus.mem_error;
        acc_en = en_cnt - e0;
        acc_wr = wr_cnt - w0;
        n_cmp++;
        if (bus.mem_stall !== 1'b0) begin
            n_bad++;
            $display("FAIL access_bound: stall=%b after %0d cycles, want 0",
                     bus.mem_stall, cyc);
        end
        bus.mem_c_en = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (bus.app_en !== 1'b0) begin
            n_bad++; $display("FAIL reset_app_en: got %b want 0", bus.app_en);
        end
        n_cmp++;
        if (bus.app_wdf_wren !== 1'b0) begin
            n_bad++; $display("FAIL reset_wren: got %b want 0", bus.app_wdf_wren);
        end
        n_cmp++;
        if (bus.mem_rdata !== 32'h0) begin
            n_bad++; $display("FAIL reset_rdata: got %h want 0", bus.mem_rdata);
        end
        n_cmp++;
        if (bus.mem_error !== 1'b0) begin
            n_bad++; $display("FAIL reset_error: got %b want 0", bus.mem_error);
        end
        n_cmp++;
        if (bus.mem_stall !== 1'b0) begin
            n_bad++; $display("FAIL reset_stall: got %b want 0", bus.mem_stall);
        end
        reset = 1'b0;
    endtask

    task automatic test_write();
        logic [31:0] rd; logic er; int cyc; exp_t e;
        sbq.push_back(model(32'h14, 1'b1, 32'hCAFE_F00D, 4'b0011));
        access(32'h14, 1'b1, 32'hCAFE_F00D, 4'b0011, rd, er, cyc);
        e = sbq.pop_front();
        n_cmp++;
        if (er !== e.er) begin
            n_bad++; $display("FAIL wr_error: got %b want %b", er, e.er);
        end
        n_cmp++;
        if (cyc !== 2) begin
            n_bad++; $display("FAIL wr_latency: got %0d want 2", cyc);
        end
        n_cmp++;
        if (cap_addr !== 28'h000_0008) begin
            n_bad++; $display("FAIL wr_app_addr: got %h want 0000008", cap_addr);
        end
        n_cmp++;
        if (cap_cmd !== 3'b000) begin
            n_bad++; $display("FAIL wr_app_cmd: got %b want 000", cap_cmd);
        end
        n_cmp++;
        if (cap_mask !== 16'hFFCF) begin
            n_bad++; $display("FAIL wr_mask: got %h want ffcf", cap_mask);
        end
        n_cmp++;
        if (cap_data !== {4{32'hCAFE_F00D}}) begin
            n_bad++; $display("FAIL wr_data: got %h want 4x cafef00d", cap_data);
        end
        n_cmp++;
        if (acc_en !== 1) begin
            n_bad++; $display("FAIL wr_app_en_cycles: got %0d want 1", acc_en);
        end
    endtask

    task automatic test_read();
        logic [31:0] rd; logic er; int cyc; exp_t e;
        logic [31:0] wa [4];
        logic [31:0] wd [4];
        wa = '{32'h10, 32'h14, 32'h18, 32'h1C};
        wd = '{32'h1111_1111, 32'hDEAD_BEEF, 32'h3333_3333, 32'h4444_4444};
        for (int i = 0; i < 4; i++) begin
            sbq.push_back(model(wa[i], 1'b1, wd[i], 4'hF));
            access(wa[i], 1'b1, wd[i], 4'hF, rd, er, cyc);
            e = sbq.pop_front();
            n_cmp++;
            if (er !== e.er) begin
                n_bad++; $display("FAIL fill_error[%0d]: got %b want %b", i, er, e.er);
            end
        end
        mig_lat = 2;
        sbq.push_back(model(32'h14, 1'b0, 32'h0, 4'h0));
        access(32'h14, 1'b0, 32'h0, 4'h0, rd, er, cyc);
        e = sbq.pop_front();
        n_cmp++;
        if (rd !== e.rd) begin
            n_bad++; $display("FAIL rd_word1: got %h want %h", rd, e.rd);
        end
        n_cmp++;
        if (er !== 1'b0) begin
            n_bad++; $display("FAIL rd_error: got %b want 0", er);
        end
        n_cmp++;
        if (cyc !== 5) begin
            n_bad++; $display("FAIL rd_latency: got %0d want 5", cyc);
        end
        mig_lat = 0;
        sbq.push_back(model(32'h1C, 1'b0, 32'h0, 4'h0));
        access(32'h1C, 1'b0, 32'h0, 4'h0, rd, er, cyc);
        e = sbq.pop_front();
        n_cmp++;
        if (rd !== e.rd) begin
            n_bad++; $display("FAIL rd_word3: got %h want %h", rd, e.rd);
        end
        n_cmp++;
        if (cyc !== 3) begin
            n_bad++; $display("FAIL rd_min_latency: got %0d want 3", cyc);
        end
    endtask

    task automatic test_calib_gate();
        logic [31:0] rd; logic er; int cyc; exp_t e;
        int e0; bit held;
        bus.init_calib_complete = 1'b0;
        @(negedge clk);
        e0 = en_cnt;
        bus.mem_addr = 32'h10;
        bus.mem_w_en = 1'b0;
        bus.mem_c_en = 1'b1;
        held = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (bus.mem_stall !== 1'b1) held = 1'b0;
        end
        n_cmp++;
        if (held !== 1'b1) begin
            n_bad++; $display("FAIL calib_stall_held: got %b want 1", held);
        end
        n_cmp++;
        if (en_cnt - e0 !== 0) begin
            n_bad++; $display("FAIL calib_app_en: got %0d want 0", en_cnt - e0);
        end
        bus.init_calib_complete = 1'b1;
        bus.mem_c_en = 1'b0;
        sbq.push_back(model(32'h10, 1'b0, 32'h0, 4'h0));
        access(32'h10, 1'b0, 32'h0, 4'h0, rd, er, cyc);
        e = sbq.pop_front();
        n_cmp++;
        if (rd !== e.rd || er !== 1'b0) begin
            n_bad++; $display("FAIL calib_read: got %h/%b want %h/0", rd, er, e.rd);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] rd; logic er; int cyc; exp_t e;
        en_wait = 5;
        wr_wait = 2;
        sbq.push_back(model(32'h20, 1'b1, 32'h1234_5678, 4'b1100));
        access(32'h20, 1'b1, 32'h1234_5678, 4'b1100, rd, er, cyc);
        e = sbq.pop_front();
        en_wait = 0;
        wr_wait = 0;
        n_cmp++;
        if (acc_en !== 6) begin
            n_bad++; $display("FAIL bp_app_en_cycles: got %0d want 6", acc_en);
        end
        n_cmp++;
        if (acc_wr !== 3) begin
            n_bad++; $display("FAIL bp_wren_cycles: got %0d want 3", acc_wr);
        end
        n_cmp++;
        if (cyc !== 7 || er !== e.er) begin
            n_bad++; $display("FAIL bp_done: got cyc %0d err %b want 7/0", cyc, er);
        end
        sbq.push_back(model(32'h20, 1'b0, 32'h0, 4'h0));
        access(32'h20, 1'b0, 32'h0, 4'h0, rd, er, cyc);
        e = sbq.pop_front();
        n_cmp++;
        if (rd !== e.rd) begin
            n_bad++; $display("FAIL bp_readback: got %h want %h", rd, e.rd);
        end
    endtask

    task automatic test_range();
        logic [31:0] rd; logic er; int cyc; exp_t e;
        sbq.push_back(model(32'h1000_0000, 1'b0, 32'h0, 4'h0));
        access(32'h1000_0000, 1'b0, 32'h0, 4'h0, rd, er, cyc);
        e = sbq.pop_front();
        n_cmp++;
        if (er !== e.er || cyc !== 1) begin
            n_bad++; $display("FAIL range_rd: got err %b cyc %0d want 1/1", er, cyc);
        end
        n_cmp++;
        if (acc_en !== 0) begin
            n_bad++; $display("FAIL range_app_en: got %0d want 0", acc_en);
        end
        sbq.push_back(model(32'hFFFF_FFFC, 1'b1, 32'h5555_5555, 4'hF));
        access(32'hFFFF_FFFC, 1'b1, 32'h5555_5555, 4'hF, rd, er, cyc);
        e = sbq.pop_front();
        n_cmp++;
        if (er !== e.er || acc_en !== 0 || acc_wr !== 0) begin
            n_bad++; $display("FAIL range_wr: got err %b en %0d want 1/0", er, acc_en);
        end
        sbq.push_back(model(32'h0FFF_FFFC, 1'b0, 32'h0, 4'h0));
        access(32'h0FFF_FFFC, 1'b0, 32'h0, 4'h0, rd, er, cyc);
        e = sbq.pop_front();
        n_cmp++;
        if (er !== e.er || rd !== e.rd) begin
            n_bad++; $display("FAIL range_top: got %h/%b want %h/%b", rd, er, e.rd, e.er);
        end
    endtask

    task automatic test_timeout();
        logic [31:0] rd; logic er; int cyc;
        mig_on = 1'b0;
        access(32'h10, 1'b0, 32'h0, 4'h0, rd, er, cyc);
        mig_on = 1'b1;
        n_cmp++;
        if (er !== 1'b1 || rd !== 32'h0) begin
            n_bad++; $display("FAIL tmo_resp: got %h/%b want 0/1", rd, er);
        end
        n_cmp++;
        if (cyc !== TMO + 3) begin
            n_bad++; $display("FAIL tmo_cycles: got %0d want %0d", cyc, TMO + 3);
        end
    endtask

    task automatic test_reset_midread();
        logic [31:0] rd; logic er; int cyc; exp_t e;
        mig_lat = 8;
        @(negedge clk);
        bus.mem_addr = 32'h18;
        bus.mem_w_en = 1'b0;
        bus.mem_c_en = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (bus.mem_stall !== 1'b1 || bus.app_en !== 1'b0) begin
            n_bad++; $display("FAIL mid_wait: got stall %b en %b want 1/0",
                              bus.mem_stall, bus.app_en);
        end
        reset = 1'b1;
        bus.mem_c_en = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        n_cmp++;
        if (bus.app_en !== 1'b0 || bus.mem_rdata !== 32'h0) begin
            n_bad++; $display("FAIL mid_reset: got en %b rdata %h want 0/0",
                              bus.app_en, bus.mem_rdata);
        end
        repeat (15) @(negedge clk);
        n_cmp++;
        if (bus.mem_rdata !== 32'h0 || bus.mem_error !== 1'b0) begin
            n_bad++; $display("FAIL late_valid: got rdata %h err %b want 0/0",
                              bus.mem_rdata, bus.mem_error);
        end
        mig_lat = 1;
        sbq.push_back(model(32'h18, 1'b0, 32'h0, 4'h0));
        access(32'h18, 1'b0, 32'h0, 4'h0, rd, er, cyc);
        e = sbq.pop_front();
        n_cmp++;
        if (rd !== e.rd || er !== 1'b0 || cyc !== 4) begin
            n_bad++; $display("FAIL post_reset_rd: got %h/%b/%0d want %h/0/4",
                              rd, er, cyc, e.rd);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd; logic er; int cyc; exp_t e;
        logic [31:0] a, d; logic w; logic [3:0] be;
        for (int i = 0; i < 24; i++) begin
            a  = {22'b0, 8'($urandom_range(0, 255)), 2'b00};
            w  = 1'($urandom_range(0, 1));
            d  = $urandom;
            be = 4'($urandom_range(0, 15));
            mig_lat = $urandom_range(0, 3);
            en_wait = $urandom_range(0, 2);
            wr_wait = $urandom_range(0, 2);
            sbq.push_back(model(a, w, d, be));
            access(a, w, d, be, rd, er, cyc);
            e = sbq.pop_front();
            n_cmp++;
            if (er !== e.er || (e.chk && rd !== e.rd)) begin
                n_bad++; $display("FAIL b2b[%0d] a=%h w=%b: got %h/%b want %h/%b",
                                  i, a, w, rd, er, e.rd, e.er);
            end
        end
        en_wait = 0;
        wr_wait = 0;
    endtask

    initial begin
        reset = 1'b1;
        bus.mem_addr = '0;
        bus.mem_wdata = '0;
        bus.mem_c_en = 1'b0;
        bus.mem_w_en = 1'b0;
        bus.mem_b_en = '0;
        bus.init_calib_complete = 1'b1;
        bus.app_rd_data = '0;
        bus.app_rd_data_valid = 1'b0;
        test_reset();
        test_write();
        test_read();
        test_calib_gate();
        test_backpressure();
        test_range();
        test_timeout();
        test_reset_midread();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
